// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard front end.
// Synchronises and deglitches the PS/2 clock and data lines, receives
// 11-bit frames (start, 8 data LSB first, odd parity, stop), decodes
// scan-code set 2 (E0 extended, F0 break, E1 Pause swallow) and keeps a
// held/released level per tracked key. Held levels persist across frames.
//
// Optional build macro: KEY_PRESS_PULSE_EN
//   When defined, adds key_press[NUM_KEYS-1:0], a one-cycle pulse on each
//   0->1 transition of keys_held (typematic repeats give no pulse).
module ps2_key_tracker #(
  parameter int                      NUM_KEYS   = 3,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES  = {9'h01C, 9'h023, 9'h029},
  parameter int                      CLK_HZ     = 100_000_000,
  parameter int                      TIMEOUT_US = 1000,
  parameter int                      FILTER_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] keys_held,
  output logic                code_valid,
  output logic [9:0]          code_out,
  output logic                frame_err
`ifdef KEY_PRESS_PULSE_EN
  ,
  output logic [NUM_KEYS-1:0] key_press
`endif
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW             = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frame_state_e;

  typedef enum logic {
    D_NORMAL,
    D_SKIP
  } dec_state_e;

  // ---------------------------------------------------------------------
  // Line synchronisers
  // ---------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  // Two-flop synchronisers; reset to the idle-high line level so no false
  // edge is seen as reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      // NOTE: sequential state is assigned with <= so every flop samples
      // the pre-edge value of its source, independent of statement order.
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // PS/2 clock glitch filter and fall strobe
  // ---------------------------------------------------------------------
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;

  // Filtered clock follows the synchronised clock only after FILTER_LEN
  // consecutive differing samples; any agreeing sample restarts the count.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
        fall_d     = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state and the one-cycle fall strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  frame_state_e  frm_state_q, frm_state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          frame_err_q, frame_err_d;

  // Frame next-state: bits are taken on each fall strobe; an idle gap of
  // TIMEOUT_CYCLES inside a frame abandons it.
  always_comb begin
    frm_state_d = frm_state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;

    if (fall_q || frm_state_q == F_IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    if (frm_state_q != F_IDLE && tmo_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      frm_state_d = F_IDLE;
      frame_err_d = 1'b1;
    end else if (fall_q) begin
      case (frm_state_q)
        F_IDLE: begin
          if (!dat_s2_q) begin
            frm_state_d = F_DATA;
            bit_cnt_d   = '0;
            par_d       = 1'b0;
          end
        end
        F_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          par_d     = par_q ^ dat_s2_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) frm_state_d = F_PARITY;
        end
        F_PARITY: begin
          par_d       = par_q ^ dat_s2_q;
          frm_state_d = F_STOP;
        end
        F_STOP: begin
          frm_state_d = F_IDLE;
          if (dat_s2_q && par_q) byte_rdy_d  = 1'b1;
          else                   frame_err_d = 1'b1;
        end
        default: frm_state_d = F_IDLE;
      endcase
    end
  end

  // Frame receiver registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_state_q <= F_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frm_state_q <= frm_state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tmo_cnt_q   <= tmo_cnt_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code decoder and key tracking
  // ---------------------------------------------------------------------
  dec_state_e          dec_state_q, dec_state_d;
  logic [2:0]          skip_cnt_q, skip_cnt_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic [NUM_KEYS-1:0] keys_held_q, keys_held_d;
  logic [9:0]          code_q, code_d;
  logic                code_valid_q, code_valid_d;

  // Decoder next-state: prefixes accumulate until a code byte consumes
  // them; shift_q holds the completed byte while byte_rdy_q is high.
  always_comb begin
    dec_state_d  = dec_state_q;
    skip_cnt_d   = skip_cnt_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    keys_held_d  = keys_held_q;
    code_d       = code_q;
    code_valid_d = 1'b0;

    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_rdy_q) begin
      if (dec_state_q == D_SKIP) begin
        // The Pause sequence is E1 followed by seven more bytes.
        skip_cnt_d = skip_cnt_q + 1'b1;
        if (skip_cnt_q == 3'd6) begin
          dec_state_d = D_NORMAL;
          skip_cnt_d  = '0;
        end
      end else begin
        case (shift_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'hE1: begin
            dec_state_d = D_SKIP;
            skip_cnt_d  = '0;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
          8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            for (int i = 0; i < NUM_KEYS; i++) begin
              if (KEY_CODES[9*i +: 9] == {ext_q, shift_q}) keys_held_d[i] = ~brk_q;
            end
            code_d       = {brk_q, ext_q, shift_q};
            code_valid_d = 1'b1;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
          end
        endcase
      end
    end
  end

  // Decoder registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_state_q  <= D_NORMAL;
      skip_cnt_q   <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keys_held_q  <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      dec_state_q  <= dec_state_d;
      skip_cnt_q   <= skip_cnt_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keys_held_q  <= keys_held_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

`ifdef KEY_PRESS_PULSE_EN
  logic [NUM_KEYS-1:0] key_press_q;

  // Press pulse registers alongside keys_held, so it lines up with the
  // 0->1 edge of the held level; a repeat make leaves held unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_press_q <= '0;
    else     key_press_q <= keys_held_d & ~keys_held_q;
  end

  assign key_press = key_press_q;
`endif

  assign keys_held  = keys_held_q;
  assign code_valid = code_valid_q;
  assign code_out   = code_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: drives PS/2 frames into ps2_key_tracker and checks
// it against a byte-level reference model of the scan-code rules.
module tb_ps2_key_tracker;

  localparam int NK     = 6;
  // key0=29 key1=23 key2=1C key3=E0 74 key4=14 key5=29 (duplicate of key0)
  localparam logic [NK*9-1:0] KC = {9'h029, 9'h014, 9'h174, 9'h01C, 9'h023, 9'h029};
  localparam int CLK_HZ = 1_000_000;
  localparam int TMO_US = 200;
  localparam int FLEN   = 8;
  localparam int TMO    = CLK_HZ / 1_000_000 * TMO_US;
  localparam int H      = 12;   // PS/2 half period in clk cycles
  localparam int GAP    = 30;   // idle cycles between frames

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          ps2_clk  = 1'b1;
  logic          ps2_data = 1'b1;
  logic [NK-1:0] keys_held;
  logic          code_valid;
  logic [9:0]    code_out;
  logic          frame_err;
`ifdef KEY_PRESS_PULSE_EN
  logic [NK-1:0] key_press;
`endif

  ps2_key_tracker #(
    .NUM_KEYS  (NK),
    .KEY_CODES (KC),
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TMO_US),
    .FILTER_LEN(FLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys_held (keys_held),
    .code_valid(code_valid),
    .code_out  (code_out),
    .frame_err (frame_err)
`ifdef KEY_PRESS_PULSE_EN
    ,
    .key_press (key_press)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling clk edge.
  int cyc = 0;
  int cv_cnt = 0, fe_cnt = 0, overlap = 0, cv_cyc = 0, kp_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid) begin
        cv_cnt++;
        cv_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (code_valid && frame_err) overlap++;
`ifdef KEY_PRESS_PULSE_EN
      kp_cnt += $countones(key_press);
`endif
    end
  end

  // Reference model: one call per received byte or per frame error.
  logic [8:0]    key_tab [NK] = '{9'h029, 9'h023, 9'h01C, 9'h174, 9'h014, 9'h029};
  logic [NK-1:0] m_held = '0;
  logic          m_ext = 1'b0, m_brk = 1'b0;
  int            m_skip = 0;
  logic [9:0]    m_code = '0;
  int            m_cv = 0, m_fe = 0, m_kp = 0;

  task automatic m_reset();
    m_held = '0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    m_code = '0;
  endtask

  task automatic m_err();
    m_fe++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    logic [NK-1:0] old;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      old = m_held;
      for (int i = 0; i < NK; i++)
        if (key_tab[i] == {m_ext, b}) m_held[i] = ~m_brk;
      m_kp  += $countones(m_held & ~old);
      m_code = {m_brk, m_ext, b};
      m_cv++;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endtask

  // PS/2 line driver.
  int stop_fall_cyc = 0;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int k = 0; k < nbits; k++) begin
      if (glitch && k == 4) begin
        cycles(1);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(H/2 - 4);
      end else begin
        cycles(H/2);
      end
      ps2_data = bits[k];
      cycles(H/2);
      ps2_clk = 1'b0;
      if (k == 10) stop_fall_cyc = cyc;
      cycles(H);
      ps2_clk = 1'b1;
    end
    cycles(H/2);
    ps2_data = 1'b1;
    cycles(GAP);
  endtask

  task automatic send_x(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    drive_bits(frame(b, bad_par, bad_stop), 11, glitch);
    if (bad_par || bad_stop) m_err();
    else                     m_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    send_x(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic verify(input string tag);
    check({tag, ".held"}, 32'(keys_held), 32'(m_held));
    check({tag, ".code"}, 32'(code_out), 32'(m_code));
    check({tag, ".cv"}, cv_cnt, m_cv);
    check({tag, ".fe"}, fe_cnt, m_fe);
`ifdef KEY_PRESS_PULSE_EN
    check({tag, ".kp"}, kp_cnt, m_kp);
`endif
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 12))
      0:       return 8'h29;
      1:       return 8'h23;
      2:       return 8'h1C;
      3:       return 8'h74;
      4:       return 8'h14;
      5, 6:    return 8'hF0;
      7, 8:    return 8'hE0;
      9:       return 8'hAA;
      10:      return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h29;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #(3_000_000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    cycles(3);
    check("rst.held", 32'(keys_held), 0);
    check("rst.code", 32'(code_out), 0);
    check("rst.cv", 32'(code_valid), 0);
    check("rst.fe", 32'(frame_err), 0);
    rst = 1'b0;
    cycles(20);

    // Make, then break, of key 29 (key0 and its duplicate key5).
    send(8'h29);
    verify("make29");
    check("latency", cv_cyc - stop_fall_cyc, FLEN + 4);
    send(8'hF0); send(8'h29);
    verify("brk29");

    // Extended key E0 74; plain 74 must not alias it.
    send(8'hE0); send(8'h74);
    verify("make_e074");
    send(8'h74);
    verify("plain74");
    send(8'hE0); send(8'hF0); send(8'h74);
    verify("brk_e074");

    // Bad parity, then a good frame.
    send_x(8'h23, 1'b1, 1'b0, 1'b0);
    verify("badpar");
    send(8'h23);
    verify("make23");

    // E0 prefix dropped by a bad stop bit.
    send(8'hE0);
    send_x(8'h1C, 1'b0, 1'b1, 1'b0);
    verify("badstop");
    send(8'h1C);
    verify("make1c");

    // Timeout mid-frame after an E0 prefix.
    send(8'hE0);
    drive_bits(frame(8'h55, 1'b0, 1'b0), 6, 1'b0);
    cycles(TMO + 20);
    m_err();
    verify("timeout");
    send(8'h74);
    verify("after_tmo74");

    // Pause sequence is swallowed whole.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    verify("pause");
    send(8'h14);
    verify("make14");

    // Short glitch on the clock line inside a frame.
    send(8'hF0);
    send_x(8'h14, 1'b0, 1'b0, 1'b1);
    verify("glitch");

    // Reset mid-frame with an E0 prefix pending.
    send(8'h29);
    send(8'hE0);
    drive_bits(frame(8'h74, 1'b0, 1'b0), 4, 1'b0);
    rst = 1'b1;
    cycles(1);
    check("midrst.held", 32'(keys_held), 0);
    check("midrst.code", 32'(code_out), 0);
    check("midrst.cv", 32'(code_valid), 0);
    check("midrst.fe", 32'(frame_err), 0);
    m_reset();
    cycles(3);
    rst = 1'b0;
    cycles(20);
    send(8'h74);
    verify("after_rst74");
    send(8'h23);
    verify("after_rst23");

    // Typematic repeat: held level stays, one press per edge.
    send(8'hF0); send(8'h29);
    send(8'h29); send(8'h29);
    verify("repeat29");

    // Randomised traffic.
    for (int n = 0; n < 50; n++) begin
      send_x(pick(), ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
      verify("rnd");
    end

    check("overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
